// File: rtl/morse_receiver.sv
// ---------------------------------------------------------------------------
// morse_receiver
// Decodes a keyed Morse line into characters of up to five elements.
// The line is synchronized and its mark and space lengths are timed in Morse
// units. Each character is then reported as a pattern of dots and dashes,
// and the end of a word is flagged separately.
//
// Parameters:
//   UNIT_CYCLES    clock cycles per Morse time unit (2..2^20)
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   morse_code_in  raw key line (async), 1 = mark, 0 = space
//   symbol_valid   1-cycle pulse, qualifies symbol_pattern/symbol_length
//   symbol_pattern element bits, first element in bit 0 (0 = dot, 1 = dash)
//   symbol_length  number of elements, 1..5
//   word_gap       1-cycle pulse at end of word
//   symbol_error   1-cycle pulse when a character exceeds five elements
// ---------------------------------------------------------------------------
module morse_receiver #(
  parameter int unsigned UNIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       morse_code_in,
  output logic       symbol_valid,
  output logic [4:0] symbol_pattern,
  output logic [2:0] symbol_length,
  output logic       word_gap,
  output logic       symbol_error
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, CHAR_DONE} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, line_q, line_prev_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      unit_q, unit_d;
  logic [4:0]      shreg_q, shreg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            word_q, word_d;
  logic [4:0]      pat_q, pat_d;
  logic [2:0]      len_q, len_d;

  logic            line_edge, line_rise, line_fall, is_dash;

  assign line_edge = line_q ^ line_prev_q;
  assign line_rise = line_q & ~line_prev_q;
  assign line_fall = ~line_q & line_prev_q;
  // A mark of two or more whole units is a dash; saturation at 7 keeps
  // arbitrarily long marks classified as dashes.
  assign is_dash   = (unit_q >= 3'd2);

  // Unit timer: any line edge restarts the measurement of the new interval.
  always_comb begin
    presc_d = presc_q;
    unit_d  = unit_q;
    if (line_edge) begin
      presc_d = '0;
      unit_d  = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      if (unit_q != 3'd7) unit_d = unit_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Character FSM.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    word_d  = 1'b0;
    pat_d   = pat_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (line_rise) begin
          state_d = MARK;
          shreg_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      MARK: begin
        if (line_fall) begin
          state_d = GAP;
          if (cnt_q < 3'd5) begin
            shreg_d = shreg_q | (5'(is_dash) << cnt_q);
            cnt_d   = cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (unit_q >= 3'd2) begin
          // Inter-character space reached: report what was collected.
          if (ovf_q) begin
            err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            pat_d   = shreg_q;
            len_d   = cnt_q;
          end
          if (line_rise) begin
            state_d = MARK;
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = CHAR_DONE;
          end
        end else if (line_rise) begin
          state_d = MARK;
        end
      end
      CHAR_DONE: begin
        if (line_rise) begin
          state_d = MARK;
          shreg_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (unit_q == 3'd5) begin
          word_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      line_q      <= 1'b0;
      line_prev_q <= 1'b0;
      presc_q     <= '0;
      unit_q      <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      word_q      <= 1'b0;
      pat_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= morse_code_in;
      line_q      <= sync1_q;
      line_prev_q <= line_q;
      presc_q     <= presc_d;
      unit_q      <= unit_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      word_q      <= word_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
    end
  end

  assign symbol_valid   = valid_q;
  assign symbol_error   = err_q;
  assign word_gap       = word_q;
  assign symbol_pattern = pat_q;
  assign symbol_length  = len_q;

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 50000, giving clock cycles per Morse time unit; legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port morse_code_in, input, 1 bit: received line, asynchronous to clk; 1 = key down (mark), 0 = space.
REQ-005 The block SHALL have port symbol_valid, output, 1 bit: one-cycle pulse that qualifies symbol_pattern and symbol_length.
REQ-006 The block SHALL have port symbol_pattern, output, 5 bits: elements of the decoded character, first element in bit 0; 0 = dot, 1 = dash; unused upper bits 0.
REQ-007 The block SHALL have port symbol_length, output, 3 bits: element count 1..5.
REQ-008 The block SHALL have port word_gap, output, 1 bit: one-cycle pulse marking end of word.
REQ-009 The block SHALL have port symbol_error, output, 1 bit: one-cycle pulse when a character is discarded for exceeding 5 elements.
REQ-010 The block SHALL register all outputs.

Function
REQ-011 The block SHALL pass morse_code_in through a 2-flop synchronizer; "line" below means the synchronized value.
REQ-012 A prescaler SHALL count 0..UNIT_CYCLES-1; on each wrap, unit_cnt (3 bits) SHALL increment, saturating at 7.
REQ-013 Every line edge (rise or fall) SHALL clear both the prescaler and unit_cnt in the same cycle.
REQ-014 FSM states SHALL be IDLE, MARK, GAP and CHAR_DONE.
REQ-015 IDLE: line rise -> MARK, with the element shift register and element count cleared.
REQ-016 MARK: line fall -> GAP; element = dash if unit_cnt >= 2 at the fall, else dot; element written at index = element count, count incremented.
REQ-017 MARK: a sixth element SHALL NOT be stored; it sets the sticky overflow flag instead; unit_cnt saturating at 7 still classifies as dash.
REQ-018 GAP: line rise while unit_cnt < 2 -> MARK, same character continues.
REQ-019 GAP: when unit_cnt becomes 2, the block SHALL, on the next cycle, pulse symbol_valid with pattern/length if overflow is clear, or else pulse symbol_error with symbol_valid low; then -> CHAR_DONE. Counting continues without clearing.
REQ-020 CHAR_DONE: line rise -> MARK, starting a new character (shift register, count and overflow cleared).
REQ-021 CHAR_DONE: when unit_cnt becomes 5, the block SHALL pulse word_gap on the next cycle and go to IDLE.
REQ-022 symbol_pattern and symbol_length SHALL hold their last values between pulses.
REQ-023 At most one of symbol_valid and symbol_error SHALL be asserted in any cycle; word_gap SHALL never coincide with either.
REQ-024 A character SHALL NOT be emitted and word_gap SHALL NOT be pulsed from IDLE, whatever the idle length.

Reset
REQ-025 While rst_n = 0, the block SHALL immediately force the following, independent of clk: state IDLE, synchronizer flops 0, prescaler, unit_cnt, element count and overflow 0, and every output 0.
REQ-026 Reset asserted mid-character SHALL discard the partial character with no pulse; after release, the next rise starts a fresh character.

Verification (UNIT_CYCLES=4)
REQ-027 'A': mark 4 cycles, space 4, mark 12, then low -> symbol_valid once with pattern 5'b00010, length 3'd2, 9-10 cycles after the final fall; no word_gap until 5 units of space.
REQ-028 'S' then word: three 4-cycle marks separated by 4-cycle spaces, then 40 cycles low -> symbol_valid with pattern 5'b00000, length 3, then word_gap exactly 12 cycles later; no further pulses.
REQ-029 Six dots with unit spacing, then 12 cycles low -> symbol_error pulse once, symbol_valid never; next 'E' (single dot) -> symbol_valid, pattern 0, length 1.
REQ-030 Mark held 100 cycles -> classified as dash; no pulses while held; after fall, pattern 5'b00001, length 1.
REQ-031 rst_n pulsed low between the 2nd and 3rd dots of 'S' -> outputs 0 during reset; no pulse for the partial character; a following 'T' decodes as pattern 1, length 1.
